rtc_bus_master: RTL and testbench
=================================

// Module: rtc_bus_master
// PURPOSE
//  Parametrised transaction engine for multiplexed address/data RTC chips (CS/RD/WR/AoD bus).
//  Runs read, write and command transactions from a one-cycle start request. Bursts of up to
//  MAX_BURST beats auto-increment the address. Strobe timing is programmable in clk cycles.
//  Sits between the general control FSM and the top-level tristate pad for the RTC data pins.
// PARAMETERS
//  DATA_W     8      width of the multiplexed address/data bus
//  MAX_BURST  16     maximum beats per transaction
//  T_SU       2      cycles from CS/AoD/bus valid to strobe assert (>=1)
//  T_PW       5      strobe low width in cycles (>=1)
//  T_HD       2      cycles from strobe release to CS release (>=1)
//  T_REC      3      cycles with CS high between phases (>=1)
//  CMD_CODE   8'hF0  byte driven during a command transaction
// PORTS
//  clk         in   1         system clock, 100 MHz
//  reset       in   1         synchronous, active-high
//  start       in   1         one-cycle request; accepted only while busy=0
//  op          in   2         00 read, 01 write, 10 command, 11 reserved (treated as read)
//  addr        in   DATA_W    first register address
//  burst_len   in   clog2(MAX_BURST+1)  beats; 0 treated as 1, >MAX_BURST clamped
//  wdata       in   DATA_W    write data for the current beat
//  wdata_pop   out  1         one-cycle pulse: wdata latched, present next word by next edge
//  rdata       out  DATA_W    read data, held until the next read beat
//  rdata_vld   out  1         one-cycle pulse per read beat
//  busy        out  1         high from start acceptance to done
//  done        out  1         one-cycle pulse at transaction end
//  cs_n,rd_n,wr_n  out 1      RTC strobes, active low
//  a_d         out  1         0 address phase, 1 data phase
//  bus_out     out  DATA_W    value for RTC pins; bus_oe out 1 pin drive enable
//  bus_in      in   DATA_W    RTC pin value from the pad
// BEHAVIOUR
//  Reset: cs_n=rd_n=wr_n=1, a_d=0, bus_oe=0, bus_out=0, busy=0, done=0, rdata=0, pulses 0.
//  Reset mid-transaction: all of the above on the next edge. No done, no partial beat.
//  Phase (P) = SETUP(T_SU) -> STROBE(T_PW) -> HOLD(T_HD) -> RECOVER(T_REC). LEN_P=T_SU+T_PW+T_HD+T_REC.
//  SETUP..HOLD: cs_n=0. RECOVER: cs_n=1, bus_oe=0, strobes high.
//  Address P: a_d=0, bus_oe=1, bus_out=current address, wr_n=0 during STROBE.
//  Data P, write: a_d=1, bus_oe=1, bus_out=latched wdata, wr_n=0 during STROBE.
//    wdata_pop pulses on the first SETUP cycle.
//  Data P, read: a_d=1, bus_oe=0, rd_n=0 during STROBE.
//    bus_in sampled on the last STROBE cycle into rdata, rdata_vld the following cycle.
//  Beat = address P + data P (2*LEN_P cycles). Command = a single address P with bus_out=CMD_CODE.
//  FSM: IDLE, ADDR_P, DATA_P, DONE. A subphase counter runs inside each P.
//  Start at edge n: first cycle of busy=1 and SETUP is n+1.
//    done is at n+1+beats*2*LEN_P (command: n+1+LEN_P). busy drops with done.
//  Bursts: address increments by 1 per beat, wrapping mod 2^DATA_W. Command ignores burst_len.
//  start while busy is ignored. op/addr/burst_len are latched at acceptance, later changes have no effect.
//  Defaults give 24 cycles (240 ns) per beat. rd_n and wr_n are never low together.
//    bus_oe=0 whenever rd_n=0.
// STRUCTURE
//  rtc_bus_defs.vh: op codes, FSM state and subphase encodings, LEN_P localparam.
//  Sub-module rtc_phase_timer: loadable down-counter. Emits subphase and last-cycle flags from the
//    T_* parameters. rtc_bus_master holds the FSM, beat counter, address/data registers.
//  Tristate (assign pin = bus_oe ? bus_out : 'z) stays in the top level.
// TESTING
//  1. Reset 3 cycles, start op=01 addr=8'h21 wdata=8'h45 len=1 -> wr_n low 5 cycles with bus_out=21/a_d=0.
//     Then wr_n low 5 cycles with bus_out=45/a_d=1. One wdata_pop. done at start+25.
//  2. op=00 addr=8'h22 len=1, model returns 8'h59 on rd_n -> rdata=59, rdata_vld 1 cycle.
//     bus_oe=0 throughout rd_n low.
//  3. op=00 addr=8'hFE len=3 -> addresses FE,FF,00 driven. 3 rdata_vld pulses. done at start+73.
//  4. op=10 -> single address phase bus_out=F0, no data phase, no pop/vld. done at start+13.
//  5. Second start during busy and reset asserted mid data strobe -> second start ignored.
//     After reset, all strobes high and bus_oe=0 next cycle, no done.
//  6. len=0 and len=20 (MAX_BURST=16) -> 1 and 16 beats. Assertion: rd_n&wr_n never both 0.

Source files
------------

// File: rtl/rtc_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// rtc_bus_master_pkg
//   Shared types for the RTC bus master: operation codes, the transaction
//   FSM state encoding, the subphase encoding used inside every bus phase,
//   and helpers for the phase length and opcode decode.
// ---------------------------------------------------------------------------
package rtc_bus_master_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CMD   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR_P,
        ST_DATA_P,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SUB_SETUP,
        SUB_STROBE,
        SUB_HOLD,
        SUB_RECOVER
    } subphase_e;

    // Cycles in one bus phase (setup + strobe + hold + recovery).
    function automatic int phase_len(input int t_su, input int t_pw,
                                     input int t_hd, input int t_rec);
        return t_su + t_pw + t_hd + t_rec;
    endfunction

    // The reserved opcode runs as a read.
    function automatic op_e decode_op(input logic [1:0] raw);
        op_e o;
        o = op_e'(raw);
        return (o == OP_RSVD) ? OP_READ : o;
    endfunction

endpackage

// File: rtl/rtc_bus_master_phase_timer.sv
// ---------------------------------------------------------------------------
// rtc_bus_master_phase_timer
//   Loadable down-counter that sequences one bus phase. The count runs from
//   LEN_P-1 to 0 and wraps, so back-to-back phases need no reload.
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   load         : restart at the first SETUP cycle on the next edge
//   en           : advance the count (phase in progress)
//   subphase     : SETUP / STROBE / HOLD / RECOVER for the current cycle
//   first_cycle  : first cycle of the phase
//   strobe_last  : last cycle of the STROBE subphase
//   last_cycle   : last cycle of the phase (end of RECOVER)
// ---------------------------------------------------------------------------
module rtc_bus_master_phase_timer
    import rtc_bus_master_pkg::*;
#(
    parameter int T_SU  = 2,
    parameter int T_PW  = 5,
    parameter int T_HD  = 2,
    parameter int T_REC = 3
)(
    input  logic      clk,
    input  logic      reset,
    input  logic      load,
    input  logic      en,
    output subphase_e subphase,
    output logic      first_cycle,
    output logic      strobe_last,
    output logic      last_cycle
);

    localparam int LEN_P = phase_len(T_SU, T_PW, T_HD, T_REC);
    localparam int CNT_W = $clog2(LEN_P);

    // The count is the number of cycles left in the phase, so each subphase
    // boundary is a fixed threshold on it.
    localparam logic [CNT_W-1:0] CNT_TOP     = CNT_W'(LEN_P - 1);
    localparam logic [CNT_W-1:0] STROBE_BEG  = CNT_W'(T_PW + T_HD + T_REC);
    localparam logic [CNT_W-1:0] HOLD_BEG    = CNT_W'(T_HD + T_REC);
    localparam logic [CNT_W-1:0] RECOVER_BEG = CNT_W'(T_REC);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= CNT_TOP;
        end else if (load) begin
            cnt <= CNT_TOP;
        end else if (en) begin
            cnt <= (cnt == '0) ? CNT_TOP : cnt - CNT_W'(1);
        end
    end

    always_comb begin
        subphase = SUB_RECOVER;
        if (cnt >= STROBE_BEG) begin
            subphase = SUB_SETUP;
        end else if (cnt >= HOLD_BEG) begin
            subphase = SUB_STROBE;
        end else if (cnt >= RECOVER_BEG) begin
            subphase = SUB_HOLD;
        end
    end

    assign first_cycle = (cnt == CNT_TOP);
    assign strobe_last = (cnt == HOLD_BEG);
    assign last_cycle  = (cnt == '0);

endmodule

// File: rtl/rtc_bus_master.sv
// ---------------------------------------------------------------------------
// rtc_bus_master
//   Transaction engine for multiplexed address/data RTC chips. A one-cycle
//   start runs a read, write or command transaction; reads and writes are
//   bursts of address-phase + data-phase beats with an auto-incrementing
//   address. The pad tristate (pin = bus_oe ? bus_out : 'z) lives in the chip
//   top level; this block only supplies bus_out/bus_oe and reads bus_in.
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle request, taken only while busy is low
//   op                : 00 read, 01 write, 10 command, 11 read
//   addr              : first register address
//   burst_len         : beats; 0 runs one beat, values above MAX_BURST clamp
//   wdata             : write data for the next beat
//   wdata_pop         : pulse, current wdata consumed, present the next word
//   rdata, rdata_vld  : read data (held) and one pulse per read beat
//   busy, done        : transaction in progress, end-of-transaction pulse
//   cs_n, rd_n, wr_n  : RTC strobes, active low
//   a_d               : 0 address phase, 1 data phase
//   bus_out, bus_oe   : value and drive enable for the RTC data pins
//   bus_in            : RTC data pins as seen through the pad
// ---------------------------------------------------------------------------
module rtc_bus_master
    import rtc_bus_master_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                MAX_BURST = 16,
    parameter int                T_SU      = 2,
    parameter int                T_PW      = 5,
    parameter int                T_HD      = 2,
    parameter int                T_REC     = 3,
    parameter logic [DATA_W-1:0] CMD_CODE  = DATA_W'(8'hF0)
)(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [1:0]                         op,
    input  logic [DATA_W-1:0]                  addr,
    input  logic [$clog2(MAX_BURST+1)-1:0]     burst_len,
    input  logic [DATA_W-1:0]                  wdata,
    output logic                               wdata_pop,
    output logic [DATA_W-1:0]                  rdata,
    output logic                               rdata_vld,
    output logic                               busy,
    output logic                               done,
    output logic                               cs_n,
    output logic                               rd_n,
    output logic                               wr_n,
    output logic                               a_d,
    output logic [DATA_W-1:0]                  bus_out,
    output logic                               bus_oe,
    input  logic [DATA_W-1:0]                  bus_in
);

    localparam int BL_W = $clog2(MAX_BURST + 1);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BL_W-1:0]   beats_q;

    subphase_e         subphase;
    logic              first_cycle, strobe_last, last_cycle;
    logic              accept, in_phase;

    function automatic logic [BL_W-1:0] clamp_beats(input logic [BL_W-1:0] n);
        if (n == '0) begin
            return BL_W'(1);
        end
        if (n > BL_W'(MAX_BURST)) begin
            return BL_W'(MAX_BURST);
        end
        return n;
    endfunction

    // The DONE cycle already has busy low, so a new start is taken there too.
    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign in_phase = (state_q == ST_ADDR_P) || (state_q == ST_DATA_P);

    rtc_bus_master_phase_timer #(
        .T_SU  (T_SU),
        .T_PW  (T_PW),
        .T_HD  (T_HD),
        .T_REC (T_REC)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .load        (accept),
        .en          (in_phase),
        .subphase    (subphase),
        .first_cycle (first_cycle),
        .strobe_last (strobe_last),
        .last_cycle  (last_cycle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cs_n      = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        a_d       = 1'b0;
        bus_oe    = 1'b0;
        bus_out   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        wdata_pop = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done    = (state_q == ST_DONE);
                state_d = accept ? ST_ADDR_P : ST_IDLE;
            end

            ST_ADDR_P: begin
                busy = 1'b1;
                if (subphase != SUB_RECOVER) begin
                    cs_n    = 1'b0;
                    bus_oe  = 1'b1;
                    bus_out = (op_q == OP_CMD) ? CMD_CODE : addr_q;
                    wr_n    = (subphase != SUB_STROBE);
                end
                if (last_cycle) begin
                    state_d = (op_q == OP_CMD) ? ST_DONE : ST_DATA_P;
                end
            end

            ST_DATA_P: begin
                busy      = 1'b1;
                a_d       = 1'b1;
                wdata_pop = (op_q == OP_WRITE) && first_cycle;
                if (subphase != SUB_RECOVER) begin
                    cs_n = 1'b0;
                    if (op_q == OP_WRITE) begin
                        bus_oe  = 1'b1;
                        bus_out = wdata_q;
                        wr_n    = (subphase != SUB_STROBE);
                    end else begin
                        rd_n = (subphase != SUB_STROBE);
                    end
                end
                if (last_cycle) begin
                    state_d = (beats_q == BL_W'(1)) ? ST_DONE : ST_ADDR_P;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write data is captured on the edge that enters the data phase, so the
    // pop in the first SETUP cycle tells the producer the word has been taken
    // and the next one is needed only by the following beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= OP_READ;
            addr_q    <= '0;
            beats_q   <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            rdata_vld <= 1'b0;
        end else begin
            rdata_vld <= 1'b0;

            if (accept) begin
                op_q    <= decode_op(op);
                addr_q  <= addr;
                beats_q <= clamp_beats(burst_len);
            end

            if ((state_q == ST_ADDR_P) && last_cycle && (op_q == OP_WRITE)) begin
                wdata_q <= wdata;
            end

            if ((state_q == ST_DATA_P) && last_cycle) begin
                addr_q  <= addr_q + DATA_W'(1);
                beats_q <= beats_q - BL_W'(1);
            end

            if ((state_q == ST_DATA_P) && (op_q != OP_WRITE) && strobe_last) begin
                rdata     <= bus_in;
                rdata_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_master.sv
module tb_rtc_bus_master;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;
    localparam int T_SU      = 2;
    localparam int T_PW      = 5;
    localparam int T_HD      = 2;
    localparam int T_REC     = 3;
    localparam int LEN_P     = T_SU + T_PW + T_HD + T_REC;
    localparam int BL_W      = $clog2(MAX_BURST + 1);
    localparam logic [7:0] CMD_CODE = 8'hF0;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [1:0]        op;
    logic [7:0]        addr;
    logic [BL_W-1:0]   burst_len;
    logic [7:0]        wdata;
    logic              wdata_pop, rdata_vld, busy, done;
    logic [7:0]        rdata;
    logic              cs_n, rd_n, wr_n, a_d, bus_oe;
    logic [7:0]        bus_out, bus_in;

    always #5 clk = ~clk;

    rtc_bus_master #(
        .DATA_W(DATA_W), .MAX_BURST(MAX_BURST),
        .T_SU(T_SU), .T_PW(T_PW), .T_HD(T_HD), .T_REC(T_REC),
        .CMD_CODE(CMD_CODE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .burst_len(burst_len), .wdata(wdata), .wdata_pop(wdata_pop),
        .rdata(rdata), .rdata_vld(rdata_vld), .busy(busy), .done(done),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    // ---------------- RTC chip model ----------------
    logic       mem_init;
    logic [7:0] rtc_mem [256];
    logic [7:0] rtc_lat;

    function automatic logic [7:0] init_val(input int a);
        if (a == 'h22) return 8'h59;
        return 8'(a * 29 + 3);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) rtc_mem[i] <= init_val(i);
            rtc_lat <= 8'h00;
        end else begin
            if (!cs_n && !wr_n && !a_d) rtc_lat <= bus_out;
            if (!cs_n && !wr_n && a_d)  rtc_mem[rtc_lat] <= bus_out;
        end
    end

    assign bus_in = (!cs_n && !rd_n) ? rtc_mem[rtc_lat] : 8'hA5;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_mem [256];
    logic [7:0] wd_words [MAX_BURST];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Runs one transaction and compares every cycle against the phase
    // structure computed from the timing parameters.
    task automatic run_txn(input logic [1:0] t_op, input logic [7:0] t_addr,
                           input logic [BL_W-1:0] t_len, input logic [7:0] t_wd0,
                           input bit disturb, input string tag,
                           output int done_k, output int n_pop, output int n_vld,
                           output logic [7:0] first_rd);
        int beats, nph, total, wd_idx, p, o, beat;
        int bad_ctl, bad_bus, bad_flag, bad_rd, bad_excl;
        bit is_wr, is_cmd;
        logic dph, rec, strb, e_wr, e_rd, e_oe, e_pop, e_vld;
        logic [7:0] e_bus;

        is_cmd = (t_op == 2'b10);
        is_wr  = (t_op == 2'b01);
        if (int'(t_len) == 0) beats = 1;
        else if (int'(t_len) > MAX_BURST) beats = MAX_BURST;
        else beats = int'(t_len);
        nph   = is_cmd ? 1 : 2 * beats;
        total = nph * LEN_P;

        wd_words[0] = t_wd0;
        for (int b = 1; b < MAX_BURST; b++) wd_words[b] = 8'($urandom);
        wd_idx = 0; done_k = -1; n_pop = 0; n_vld = 0; first_rd = 8'h00;
        bad_ctl = 0; bad_bus = 0; bad_flag = 0; bad_rd = 0; bad_excl = 0;

        @(posedge clk); #1;
        start = 1'b1; op = t_op; addr = t_addr; burst_len = t_len; wdata = wd_words[0];
        @(posedge clk); #1;
        start = 1'b0;
        if (disturb) begin
            op = 2'($urandom); addr = 8'($urandom); burst_len = BL_W'($urandom);
        end

        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            if (done === 1'b1 && done_k < 0) done_k = k;
            if (k < total) begin
                p = k / LEN_P; o = k % LEN_P; beat = p / 2;
                dph  = ((p % 2) == 1);
                rec  = (o >= LEN_P - T_REC);
                strb = (o >= T_SU) && (o < T_SU + T_PW);
                e_wr = !(strb && (!dph || is_wr));
                e_rd = !(strb && dph && !is_wr);
                e_oe = !rec && (!dph || is_wr);
                if (cs_n !== rec || a_d !== dph || wr_n !== e_wr || rd_n !== e_rd ||
                    bus_oe !== e_oe || busy !== 1'b1 || done !== 1'b0) bad_ctl++;
                if (e_oe) begin
                    e_bus = !dph ? (is_cmd ? CMD_CODE : 8'(int'(t_addr) + beat)) : wd_words[beat];
                    if (bus_out !== e_bus) bad_bus++;
                end
                e_pop = dph && is_wr && (o == 0);
                e_vld = dph && !is_wr && (o == T_SU + T_PW);
                if (wdata_pop !== e_pop || rdata_vld !== e_vld) bad_flag++;
            end else begin
                if (done !== 1'b1 || busy !== 1'b0 || cs_n !== 1'b1 || rd_n !== 1'b1 ||
                    wr_n !== 1'b1 || bus_oe !== 1'b0 || wdata_pop !== 1'b0) bad_ctl++;
            end
            if ((rd_n === 1'b0 && wr_n === 1'b0) || (rd_n === 1'b0 && bus_oe === 1'b1)) bad_excl++;
            if (wdata_pop === 1'b1) begin
                n_pop++; wd_idx++;
                if (wd_idx < MAX_BURST) wdata = wd_words[wd_idx];
            end
            if (rdata_vld === 1'b1) begin
                n_vld++;
                if (n_vld == 1) first_rd = rdata;
                if (rdata !== exp_mem[8'(int'(t_addr) + n_vld - 1)]) bad_rd++;
            end
            if (disturb && k >= 1 && k + 4 <= total && $urandom_range(0, 15) == 0) begin
                start = 1'b1; op = 2'($urandom); addr = 8'($urandom); burst_len = BL_W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;

        if (is_wr) begin
            for (int b = 0; b < beats; b++) exp_mem[8'(int'(t_addr) + b)] = wd_words[b];
        end

        check({tag, ".ctl_bad_cycles"},  bad_ctl,  0);
        check({tag, ".bus_bad_cycles"},  bad_bus,  0);
        check({tag, ".flag_bad_cycles"}, bad_flag, 0);
        check({tag, ".rdata_bad"},       bad_rd,   0);
        check({tag, ".rd_wr_excl_bad"},  bad_excl, 0);
        check({tag, ".done_at"},         done_k,   total);
        check({tag, ".pops"},            n_pop,    is_wr ? beats : 0);
        check({tag, ".vlds"},            n_vld,    (!is_wr && !is_cmd) ? beats : 0);
    endtask

    typedef struct {
        logic [1:0]      op;
        logic [7:0]      addr;
        logic [BL_W-1:0] len;
        logic [7:0]      wd0;
        int              exp_done;
        int              exp_pops;
        int              exp_vlds;
        bit              chk_rd;
        logic [7:0]      exp_rd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dk, np, nv, cnt_bad;
        logic [7:0] fr;

        reset = 1'b1; mem_init = 1'b1; start = 1'b0; op = 2'b00; addr = 8'h00;
        burst_len = '0; wdata = 8'h00;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);

        vecs[0] = '{op:2'b01, addr:8'h21, len:BL_W'(1),  wd0:8'h45, exp_done:24,  exp_pops:1,  exp_vlds:0, chk_rd:1'b0, exp_rd:8'h00};
        vecs[1] = '{op:2'b00, addr:8'h22, len:BL_W'(1),  wd0:8'h00, exp_done:24,  exp_pops:0,  exp_vlds:1, chk_rd:1'b1, exp_rd:8'h59};
        vecs[2] = '{op:2'b00, addr:8'hFE, len:BL_W'(3),  wd0:8'h00, exp_done:72,  exp_pops:0,  exp_vlds:3, chk_rd:1'b0, exp_rd:8'h00};
        vecs[3] = '{op:2'b10, addr:8'h33, len:BL_W'(5),  wd0:8'h00, exp_done:12,  exp_pops:0,  exp_vlds:0, chk_rd:1'b0, exp_rd:8'h00};
        vecs[4] = '{op:2'b00, addr:8'h10, len:BL_W'(0),  wd0:8'h00, exp_done:24,  exp_pops:0,  exp_vlds:1, chk_rd:1'b0, exp_rd:8'h00};
        vecs[5] = '{op:2'b01, addr:8'h50, len:BL_W'(20), wd0:8'h7E, exp_done:384, exp_pops:16, exp_vlds:0, chk_rd:1'b0, exp_rd:8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.cs_n",      int'(cs_n),      1);
        check("reset.rd_n",      int'(rd_n),      1);
        check("reset.wr_n",      int'(wr_n),      1);
        check("reset.a_d",       int'(a_d),       0);
        check("reset.bus_oe",    int'(bus_oe),    0);
        check("reset.bus_out",   int'(bus_out),   0);
        check("reset.busy",      int'(busy),      0);
        check("reset.done",      int'(done),      0);
        check("reset.rdata",     int'(rdata),     0);
        check("reset.rdata_vld", int'(rdata_vld), 0);
        check("reset.wdata_pop", int'(wdata_pop), 0);
        reset = 1'b0; mem_init = 1'b0;

        // Directed table
        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].wd0, 1'b0,
                    $sformatf("vec%0d", v), dk, np, nv, fr);
            check($sformatf("vec%0d.tbl_done", v), dk, vecs[v].exp_done);
            check($sformatf("vec%0d.tbl_pops", v), np, vecs[v].exp_pops);
            check($sformatf("vec%0d.tbl_vlds", v), nv, vecs[v].exp_vlds);
            if (vecs[v].chk_rd) check($sformatf("vec%0d.tbl_rdata", v), int'(fr), int'(vecs[v].exp_rd));
        end

        // Second start while busy, then reset in the middle of a data strobe
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; addr = 8'h40; burst_len = BL_W'(2); wdata = 8'h3C;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= LEN_P + T_SU + 1; k++) begin
            @(negedge clk);
            if (k == 3) begin
                start = 1'b1; op = 2'b10; addr = 8'h99; burst_len = BL_W'(1);
            end else begin
                start = 1'b0;
            end
        end
        check("rst_mid.wr_n_in_strobe", int'(wr_n),    0);
        check("rst_mid.a_d_in_strobe",  int'(a_d),     1);
        check("rst_mid.bus_out_data",   int'(bus_out), 'h3C);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid.cs_n",   int'(cs_n),   1);
        check("rst_mid.rd_n",   int'(rd_n),   1);
        check("rst_mid.wr_n",   int'(wr_n),   1);
        check("rst_mid.bus_oe", int'(bus_oe), 0);
        check("rst_mid.busy",   int'(busy),   0);
        check("rst_mid.done",   int'(done),   0);
        reset = 1'b0;
        exp_mem[8'h40] = 8'h3C;
        cnt_bad = 0;
        for (int k = 0; k < 3 * LEN_P; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b0) cnt_bad++;
        end
        check("rst_mid.quiet_after", cnt_bad, 0);

        // Randomized transactions with input disturbance while busy
        for (int t = 0; t < 30; t++) begin
            run_txn(2'($urandom), 8'($urandom), BL_W'($urandom_range(0, 20)), 8'($urandom),
                    1'b1, $sformatf("rnd%0d", t), dk, np, nv, fr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
